// File: rtl/rand_share_arbiter_pkg.sv
// rand_pkg: LFSR tap table and FSM state type shared by the random-share arbiter.
package rand_pkg;

    typedef enum logic {WARMUP, RUN} rand_state_e;

    function automatic logic [7:0] tap_mask(input int w);
        return w == 3 ? 8'b0000_0110 :
               w == 4 ? 8'b0000_1100 :
               w == 5 ? 8'b0001_0100 :
               w == 6 ? 8'b0011_0000 :
               w == 7 ? 8'b0110_0000 :
                        8'b1011_1000;
    endfunction

endpackage

// File: rtl/rand_share_arbiter_if.sv
// rand_share_arbiter_if: requester-side bus of the random-share arbiter.
interface rand_share_arbiter_if #(
    parameter int N_REQ = 2,
    parameter int W     = 8
);
    logic             hold;
    logic [N_REQ-1:0] req;
    logic [N_REQ-1:0] gnt;
    logic [W-1:0]     rand_out;
    logic             ready;

    modport master (output hold, req, input gnt, rand_out, ready);
    modport slave (input hold, req, output gnt, rand_out, ready);
endinterface

// File: rtl/rand_share_arbiter_lfsr.sv
// lfsr_xnor_core: XNOR-feedback shift register; zero reset state never locks up.
module lfsr_xnor_core
    import rand_pkg::*;
#(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    output logic [W-1:0] q
);
    localparam logic [W-1:0] MASK = W'(tap_mask(W));

    logic [W-1:0] q_q, q_d;

    always_comb q_d = en ? {q_q[W-2:0], ~^(q_q & MASK)} : q_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) q_q <= '0;
        else       q_q <= q_d;
    end

    assign q = q_q;
endmodule

// File: rtl/rand_share_arbiter.sv
// rand_share_arbiter: round-robin sharing of one LFSR among requesters,
// withholding grants while the LFSR value exceeds MAX_VAL.
module rand_share_arbiter
    import rand_pkg::*;
#(
    parameter int N_REQ   = 2,
    parameter int W       = 8,
    parameter int MAX_VAL = 200,
    parameter int WARM    = 16
) (
    input logic                 clk,
    input logic                 reset,
    rand_share_arbiter_if.slave bus
);
    localparam int PW = N_REQ > 1 ? $clog2(N_REQ) : 1;

    rand_state_e      state_q, state_d;
    logic [7:0]       warm_q, warm_d;
    logic [PW-1:0]    ptr_q, ptr_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [W-1:0]     rand_q, rand_d;
    logic             ready_q, ready_d;
    logic [W-1:0]     lfsr;
    logic [PW-1:0]    idx, cand;
    logic             found, advance;

    lfsr_xnor_core #(.W(W)) u_lfsr (
        .clk   (clk),
        .reset (reset),
        .en    (!bus.hold),
        .q     (lfsr)
    );

    always_comb begin
        idx   = ptr_q;
        cand  = ptr_q;
        found = 1'b0;
        // Walk offsets downward so the nearest request above the pointer wins.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % N_REQ);
            if (bus.req[idx]) begin
                found = 1'b1;
                cand  = idx;
            end
        end
        advance = !bus.hold && state_q == RUN && found && int'(lfsr) <= MAX_VAL;
        warm_d  = (!bus.hold && state_q == WARMUP) ? warm_q + 8'd1 : warm_q;
        state_d = (!bus.hold && state_q == WARMUP && (WARM == 0 || int'(warm_q) == WARM - 1))
                  ? RUN : state_q;
        ptr_d   = advance ? PW'((int'(cand) + 1) % N_REQ) : ptr_q;
        gnt_d   = advance ? N_REQ'(1) << cand : '0;
        rand_d  = advance ? lfsr : rand_q;
        ready_d = state_d == RUN;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= WARMUP;
            warm_q  <= '0;
            ptr_q   <= '0;
            gnt_q   <= '0;
            rand_q  <= '0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            warm_q  <= warm_d;
            ptr_q   <= ptr_d;
            gnt_q   <= gnt_d;
            rand_q  <= rand_d;
            ready_q <= ready_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.rand_out = rand_q;
    assign bus.ready    = ready_q;
endmodule
